// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ valid/ready
// producers, with a burst lock so a granted producer keeps the port for up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_write_o,
  output logic [DATA_W-1:0]       fifo_wdata_o,
  output logic [ID_W-1:0]         fifo_wid_o,
  output logic                    lock_active_o,
  output logic                    dbg_locked_o,
  output logic [CNT_W-1:0]        dbg_burst_cnt_o,
  output logic [ID_W-1:0]         dbg_last_id_o
);

  // Handshake: a beat moves when req_valid_i[i] && req_ready_o[i] in the same cycle;
  // req_ready_o depends only on registered state, req_valid_i and fifo_full_i, never on itself.

  if (N_REQ < 2) begin : g_bad_n_req
    $error("fifo_wr_arbiter: N_REQ must be >= 2");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
  end

  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic             lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             locked;
  logic             rr_found;
  logic [ID_W-1:0]  rr_id;
  logic [ID_W-1:0]  gnt;
  logic             acc;
  logic [ID_W:0]    rr_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q   <= ID_W'(N_REQ - 1);
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      last_id_q   <= last_id_d;
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output / grant logic: locked owner first, else rotating search from last_id+1
  always_comb begin
    locked       = lock_vld_q && req_valid_i[lock_id_q] && (burst_cnt_q < CNT_W'(MAX_BURST));
    rr_found     = 1'b0;
    rr_id        = '0;
    rr_sum       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_id_q} + (ID_W + 1)'(k);
      if (rr_sum >= (ID_W + 1)'(N_REQ)) rr_sum = rr_sum - (ID_W + 1)'(N_REQ);
      if (!rr_found && req_valid_i[rr_sum[ID_W-1:0]]) begin
        rr_found = 1'b1;
        rr_id    = rr_sum[ID_W-1:0];
      end
    end
    gnt          = locked ? lock_id_q : rr_id;
    acc          = (locked || rr_found) && !fifo_full_i && !rst;
    fifo_write_o = acc;
    fifo_wid_o   = gnt;
    fifo_wdata_o = '0;
    req_ready_o  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        fifo_wdata_o   = req_data_i[i*DATA_W +: DATA_W];
        req_ready_o[i] = acc;
      end
    end
    lock_active_o   = lock_vld_q;
    dbg_locked_o    = locked;
    dbg_burst_cnt_o = burst_cnt_q;
    dbg_last_id_o   = last_id_q;
  end

  // Next-state logic; a full FIFO freezes everything
  always_comb begin
    last_id_d   = last_id_q;
    lock_vld_d  = lock_vld_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    if (!fifo_full_i) begin
      if (lock_vld_q && !req_valid_i[lock_id_q]) begin
        lock_vld_d  = 1'b0;
        burst_cnt_d = '0;
      end
      if (acc) begin
        last_id_d = gnt;
        if (locked) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          lock_id_d   = gnt;
          burst_cnt_d = CNT_W'(1);
          lock_vld_d  = 1'b1;
        end
        if (burst_cnt_d == CNT_W'(MAX_BURST)) begin
          lock_vld_d  = 1'b0;
          burst_cnt_d = '0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  a_no_write_full: assert property (@(posedge clk) disable iff (rst) fifo_write_o |-> !fifo_full_i);
  a_cnt_range:     assert property (@(posedge clk) disable iff (rst) burst_cnt_q <= CNT_W'(MAX_BURST));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: MAX_BURST=4 instance for most steps,
// a MAX_BURST=1 instance for plain round-robin.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  req_ready;
  logic          fifo_write;
  logic [DW-1:0] fifo_wdata;
  logic [1:0]    fifo_wid;
  logic          lock_active;
  logic          dbg_locked;
  logic [2:0]    dbg_burst_cnt;
  logic [1:0]    dbg_last_id;

  logic [N-1:0]  rr_valid = '0;
  logic [N-1:0]  rr_ready;
  logic          rr_write;
  logic [DW-1:0] rr_wdata;
  logic [1:0]    rr_wid;
  logic          rr_lock_active;
  logic          rr_dbg_locked;
  logic          rr_dbg_burst_cnt;
  logic [1:0]    rr_dbg_last_id;

  int n_chk  = 0;
  int n_pass = 0;

  // Clock / reset
  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_full_i(fifo_full), .fifo_write_o(fifo_write),
    .fifo_wdata_o(fifo_wdata), .fifo_wid_o(fifo_wid), .lock_active_o(lock_active),
    .dbg_locked_o(dbg_locked), .dbg_burst_cnt_o(dbg_burst_cnt), .dbg_last_id_o(dbg_last_id)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut_rr (
    .clk(clk), .rst(rst), .req_valid_i(rr_valid), .req_data_i(req_data),
    .req_ready_o(rr_ready), .fifo_full_i(1'b0), .fifo_write_o(rr_write),
    .fifo_wdata_o(rr_wdata), .fifo_wid_o(rr_wid), .lock_active_o(rr_lock_active),
    .dbg_locked_o(rr_dbg_locked), .dbg_burst_cnt_o(rr_dbg_burst_cnt), .dbg_last_id_o(rr_dbg_last_id)
  );

  function automatic logic [DW-1:0] dat(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are changed just after posedge; outputs are checked at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rr_valid = '0;
    fifo_full = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic exp_beat(input string tag, input int id, input logic lk);
    @(negedge clk);
    chk({tag, "_write"}, DW'(fifo_write), DW'(1));
    chk({tag, "_wid"}, DW'(fifo_wid), DW'(id));
    chk({tag, "_wdata"}, fifo_wdata, dat(id));
    chk({tag, "_ready"}, DW'(req_ready), DW'(4'b0001 << id));
    chk({tag, "_lock"}, DW'(lock_active), DW'(lk));
    next_cycle();
  endtask

  task automatic exp_idle(input string tag);
    @(negedge clk);
    chk({tag, "_write"}, DW'(fifo_write), DW'(0));
    chk({tag, "_ready"}, DW'(req_ready), DW'(0));
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat(i);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour: outputs suppressed even with all requesters valid
    rst = 1'b1;
    req_valid = 4'b1111;
    next_cycle();
    @(negedge clk);
    chk("rst_write", DW'(fifo_write), DW'(0));
    chk("rst_ready", DW'(req_ready), DW'(0));
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_lock", DW'(lock_active), DW'(0));
    chk("rst_cnt", DW'(dbg_burst_cnt), DW'(0));
    chk("rst_last_id", DW'(dbg_last_id), DW'(3));
    chk("idle_write", DW'(fifo_write), DW'(0));
    chk("idle_ready", DW'(req_ready), DW'(0));
    next_cycle();

    // Full rotation with MAX_BURST=4
    req_valid = 4'b1111;
    for (int c = 0; c < 17; c++) exp_beat("rot", (c / 4) % 4, (c % 4) != 0);

    // Early lock release
    do_reset();
    req_valid = 4'b0100;
    exp_beat("rel_a", 2, 1'b0);
    exp_beat("rel_b", 2, 1'b1);
    req_valid = 4'b1010;
    exp_beat("rel_c", 3, 1'b1);
    for (int c = 0; c < 3; c++) exp_beat("rel_d", 3, 1'b1);
    exp_beat("rel_e", 1, 1'b0);

    // Full stall in the middle of a burst
    do_reset();
    req_valid = 4'b0011;
    exp_beat("stl_a", 0, 1'b0);
    exp_beat("stl_b", 0, 1'b1);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stl_write", DW'(fifo_write), DW'(0));
      chk("stl_ready", DW'(req_ready), DW'(0));
      chk("stl_cnt", DW'(dbg_burst_cnt), DW'(2));
      chk("stl_lock", DW'(lock_active), DW'(1));
      next_cycle();
    end
    fifo_full = 1'b0;
    exp_beat("stl_c", 0, 1'b1);
    exp_beat("stl_d", 0, 1'b1);
    exp_beat("stl_e", 1, 1'b0);

    // Pure round-robin on the MAX_BURST=1 instance
    do_reset();
    rr_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_write", DW'(rr_write), DW'(1));
      chk("rr_wid", DW'(rr_wid), DW'(c % 4));
      chk("rr_wdata", rr_wdata, dat(c % 4));
      chk("rr_lock", DW'(rr_lock_active), DW'(0));
      next_cycle();
    end
    rr_valid = '0;

    // Reset in the middle of req1's burst
    do_reset();
    req_valid = 4'b0011;
    @(negedge clk);
    chk("mid_last_id", DW'(dbg_last_id), DW'(3));
    next_cycle();
    // the cycle above was req0's first beat; continue the burst
    for (int c = 1; c < 4; c++) exp_beat("mid_a", 0, 1'b1);
    exp_beat("mid_b", 1, 1'b0);
    exp_beat("mid_c", 1, 1'b1);
    rst = 1'b1;
    exp_idle("mid_rst");
    rst = 1'b0;
    exp_beat("mid_d", 0, 1'b0);
    for (int c = 1; c < 4; c++) exp_beat("mid_e", 0, 1'b1);
    exp_beat("mid_f", 1, 1'b0);

    // Single requester streaming with back-to-back bursts
    do_reset();
    req_valid = 4'b1000;
    for (int c = 0; c < 12; c++) exp_beat("one", 3, (c % 4) != 0);
    req_valid = '0;
    exp_idle("end_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
